pwm_seq_ctrl: RTL and testbench

//  Sequencer for one pattern_pwm instance. Holds a small table of PWM descriptors
//  (duty_num, pulse_dessert, pulse_num, PAT, dwell), plays them back-to-back, and

---
 rtl/pwm_seq_pkg.sv | 24 ++
 rtl/pwm_seq_ctrl_if.sv | 24 ++
 rtl/pwm_seq_desc_ram.sv | 31 +++
 rtl/pwm_seq_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_pwm_seq_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types and field widths for the PWM descriptor sequencer.
package pwm_seq_pkg;

  localparam int DUTY_W    = 8;
  localparam int DESSERT_W = 16;
  localparam int PNUM_W    = 8;
  localparam int DWELL_W   = 16;
  localparam int LOOP_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STOP,
    S_GAP,
    S_DONE
  } seq_state_e;

  // Requested table length saturates at the table depth.
  function automatic int unsigned clamp_len(int unsigned len, int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/pwm_seq_ctrl_if.sv
// Control/handshake bundle between the sequencer and one pattern_pwm instance.
interface pwm_seq_ctrl_if #(
  parameter int PAT_WIDTH = 16
);
  import pwm_seq_pkg::*;

  logic                 pwm_en;
  logic [DUTY_W-1:0]    duty_num;
  logic [DESSERT_W-1:0] pulse_dessert;
  logic [PNUM_W-1:0]    pulse_num;
  logic [PAT_WIDTH-1:0] PAT;
  logic                 pwm_valid;

  modport master (
    output pwm_en, duty_num, pulse_dessert, pulse_num, PAT,
    input  pwm_valid
  );

  modport slave (
    input  pwm_en, duty_num, pulse_dessert, pulse_num, PAT,
    output pwm_valid
  );

endinterface

// File: rtl/pwm_seq_desc_ram.sv
// Descriptor table: one write port, one enabled registered read port.
module pwm_seq_desc_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the table must read back as zero after reset, so the array is
  // cleared here and therefore maps to flops rather than a RAM primitive.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (we)    mem[wr_addr] <= wr_data;
      if (rd_en) rd_data      <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Plays a table of PWM descriptors back-to-back into one pattern_pwm,
// handling finite/infinite bursts, inter-burst gaps, looping and timeouts.
module pwm_seq_ctrl
  import pwm_seq_pkg::*;
#(
  parameter int  _PAT_WIDTH = 16,
  parameter int  _DEPTH     = 8,
  parameter int  _GAP_CYC   = 2,
  parameter int  _TIMEOUT   = 65535,
  localparam int IDX_W      = $clog2(_DEPTH),
  localparam int LEN_W      = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_addr,
  input  logic [DUTY_W-1:0]     cfg_duty,
  input  logic [DESSERT_W-1:0]  cfg_dessert,
  input  logic [PNUM_W-1:0]     cfg_pnum,
  input  logic [_PAT_WIDTH-1:0] cfg_pat,
  input  logic [DWELL_W-1:0]    cfg_dwell,
  input  logic [LEN_W-1:0]      seq_len,
  input  logic [LOOP_W-1:0]     loop_cnt,
  input  logic                  start,
  input  logic                  stop,
  pwm_seq_ctrl_if.master        pwm,
  output logic                  seq_busy,
  output logic                  seq_done,
  output logic [IDX_W-1:0]      cur_idx,
  output logic                  err
);

  localparam int GAP_W = (_GAP_CYC > 1) ? $clog2(_GAP_CYC) : 1;
  localparam int TMO_W = $clog2(_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(_TIMEOUT);

  typedef struct packed {
    logic [DUTY_W-1:0]     duty;
    logic [DESSERT_W-1:0]  dessert;
    logic [PNUM_W-1:0]     pnum;
    logic [_PAT_WIDTH-1:0] pat;
    logic [DWELL_W-1:0]    dwell;
  } pwm_desc_t;

  seq_state_e       state;
  pwm_desc_t        wr_desc, cur;
  logic             pwm_en_r, abort_r;
  logic [IDX_W-1:0] idx_r, rd_addr;
  logic [LEN_W-1:0] len_r, start_len;
  logic [LOOP_W-1:0] loop_r, pass_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             rd_en, more_idx, more_pass, is_inf;

  assign wr_desc   = '{duty: cfg_duty, dessert: cfg_dessert, pnum: cfg_pnum,
                       pat: cfg_pat, dwell: cfg_dwell};
  assign start_len = LEN_W'(clamp_len(32'(seq_len), 32'(_DEPTH)));
  assign is_inf    = (cur.pnum == '0);
  assign more_idx  = (LEN_W'(idx_r) + LEN_W'(1)) < len_r;
  assign more_pass = (loop_r == '0) || ((pass_cnt + LOOP_W'(1)) != loop_r);

  // The read register doubles as the field output register, so it only
  // advances when a new descriptor is loaded and holds through RUN/STOP.
  pwm_seq_desc_ram #(
    .DEPTH (_DEPTH),
    .WIDTH ($bits(pwm_desc_t))
  ) u_desc_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg_we && !seq_busy),
    .wr_addr (cfg_addr),
    .wr_data (wr_desc),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (cur)
  );

  assign pwm.pwm_en        = pwm_en_r;
  assign pwm.duty_num      = cur.duty;
  assign pwm.pulse_dessert = cur.dessert;
  assign pwm.pulse_num     = cur.pnum;
  assign pwm.PAT           = cur.pat;
  assign cur_idx           = idx_r;

  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    unique case (state)
      S_IDLE: rd_en = start && !stop && (start_len != '0);
      S_GAP: begin
        if (!stop && gap_cnt == '0 && (more_idx || more_pass)) begin
          rd_en   = 1'b1;
          rd_addr = more_idx ? idx_r + IDX_W'(1) : '0;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pwm_en_r  <= 1'b0;
      abort_r   <= 1'b0;
      idx_r     <= '0;
      len_r     <= '0;
      loop_r    <= '0;
      pass_cnt  <= '0;
      gap_cnt   <= '0;
      dwell_cnt <= '0;
      tmo_cnt   <= '0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !stop) begin
            err      <= 1'b0;
            abort_r  <= 1'b0;
            len_r    <= start_len;
            loop_r   <= loop_cnt;
            pass_cnt <= '0;
            idx_r    <= '0;
            seq_busy <= 1'b1;
            if (start_len == '0) begin
              state    <= S_DONE;
              seq_done <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (stop) begin
            state    <= S_DONE;
            seq_done <= 1'b1;
          end else begin
            state     <= S_RUN;
            pwm_en_r  <= 1'b1;
            tmo_cnt   <= '0;
            dwell_cnt <= (cur.dwell == '0) ? '0 : cur.dwell - DWELL_W'(1);
          end
        end
        S_RUN: begin
          if (is_inf) begin
            // Infinite bursts ignore pwm_valid until the dwell has expired.
            if (stop || dwell_cnt == '0) begin
              pwm_en_r <= 1'b0;
              abort_r  <= stop;
              tmo_cnt  <= '0;
              state    <= S_STOP;
            end else begin
              dwell_cnt <= dwell_cnt - DWELL_W'(1);
            end
          end else if (pwm.pwm_valid) begin
            pwm_en_r <= 1'b0;
            if (stop) begin
              state    <= S_DONE;
              seq_done <= 1'b1;
            end else begin
              state   <= S_GAP;
              gap_cnt <= GAP_W'(_GAP_CYC - 1);
            end
          end else if (stop) begin
            pwm_en_r <= 1'b0;
            abort_r  <= 1'b1;
            tmo_cnt  <= '0;
            state    <= S_STOP;
          end else if (tmo_cnt == TMO_MAX) begin
            pwm_en_r <= 1'b0;
            err      <= 1'b1;
            state    <= S_DONE;
            seq_done <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_STOP: begin
          if (pwm.pwm_valid) begin
            if (abort_r) begin
              state    <= S_DONE;
              seq_done <= 1'b1;
            end else begin
              state   <= S_GAP;
              gap_cnt <= GAP_W'(_GAP_CYC - 1);
            end
          end else if (tmo_cnt == TMO_MAX) begin
            err      <= 1'b1;
            state    <= S_DONE;
            seq_done <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_GAP: begin
          if (stop) begin
            state    <= S_DONE;
            seq_done <= 1'b1;
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end else if (rd_en) begin
            state <= S_LOAD;
            idx_r <= rd_addr;
            if (!more_idx && loop_r != '0) pass_cnt <= pass_cnt + LOOP_W'(1);
          end else begin
            state    <= S_DONE;
            seq_done <= 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          seq_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Scoreboard bench for pwm_seq_ctrl with a behavioural pattern_pwm load.
module tb_pwm_seq_ctrl;
  import pwm_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [7:0]  cfg_duty = '0;
  logic [15:0] cfg_dessert = '0;
  logic [7:0]  cfg_pnum = '0;
  logic [15:0] cfg_pat = '0;
  logic [15:0] cfg_dwell = '0;
  logic [3:0]  seq_len = '0;
  logic [7:0]  loop_cnt = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        seq_busy, seq_done, err;
  logic [2:0]  cur_idx;

  pwm_seq_ctrl_if #(.PAT_WIDTH(16)) pwm_if ();

  pwm_seq_ctrl #(
    ._PAT_WIDTH (16),
    ._DEPTH     (8),
    ._GAP_CYC   (2),
    ._TIMEOUT   (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_duty    (cfg_duty),
    .cfg_dessert (cfg_dessert),
    .cfg_pnum    (cfg_pnum),
    .cfg_pat     (cfg_pat),
    .cfg_dwell   (cfg_dwell),
    .seq_len     (seq_len),
    .loop_cnt    (loop_cnt),
    .start       (start),
    .stop        (stop),
    .pwm         (pwm_if),
    .seq_busy    (seq_busy),
    .seq_done    (seq_done),
    .cur_idx     (cur_idx),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  string tag = "reset";

  task automatic check(string name, longint act, longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s/%s: got %0d (0x%0h), expected %0d (0x%0h)", tag, name, act, act, exp, exp);
    end
  endtask

  // Expected-response records; hi/low/lat below zero mean "not checked".
  typedef struct {
    int idx; int duty; int dessert; int pnum; int pat; int hi; int low;
  } burst_t;
  typedef struct { int err; int lat; } done_t;

  burst_t exp_burst_q[$];
  done_t  exp_done_q[$];

  // Behavioural pattern_pwm: finite bursts complete after 3*pulse_num enabled
  // cycles; an early/infinite disable is acknowledged 3 cycles after en falls.
  typedef enum int { M_IDLE, M_ON, M_OFF, M_WAIT } mstate_e;
  mstate_e mst = M_IDLE;
  int      m_cnt = 0;
  bit      vld_ena = 1'b1;

  initial pwm_if.pwm_valid = 1'b0;

  always @(negedge clk) begin
    pwm_if.pwm_valid = 1'b0;
    case (mst)
      M_IDLE: if (pwm_if.pwm_en) begin mst = M_ON; m_cnt = 1; end
      M_ON: begin
        if (!pwm_if.pwm_en) begin
          mst = M_OFF; m_cnt = 1;
        end else begin
          m_cnt++;
          if (pwm_if.pulse_num != 0 && m_cnt == 3 * int'(pwm_if.pulse_num) && vld_ena) begin
            pwm_if.pwm_valid = 1'b1;
            mst = M_WAIT;
          end
        end
      end
      M_OFF: begin
        m_cnt++;
        if (m_cnt == 3) begin
          pwm_if.pwm_valid = vld_ena;
          mst = M_IDLE;
        end
      end
      M_WAIT: if (!pwm_if.pwm_en) mst = M_IDLE;
      default: mst = M_IDLE;
    endcase
  end

  // Monitor: pops an expectation on every burst start/end and every seq_done.
  bit     en_prev = 1'b0;
  bit     have_b = 1'b0;
  int     rise_cyc = 0;
  int     fall_cyc = 0;
  burst_t cur_b;

  always @(negedge clk) begin
    if (!rst) begin
      if (pwm_if.pwm_en && !en_prev) begin
        rise_cyc = cyc;
        if (exp_burst_q.size() == 0) begin
          check("unexpected_burst", 1, 0);
        end else begin
          cur_b  = exp_burst_q.pop_front();
          have_b = 1'b1;
          check("burst_idx", cur_idx, cur_b.idx);
          check("burst_duty", pwm_if.duty_num, cur_b.duty);
          check("burst_dessert", pwm_if.pulse_dessert, cur_b.dessert);
          check("burst_pnum", pwm_if.pulse_num, cur_b.pnum);
          check("burst_pat", pwm_if.PAT, cur_b.pat);
          if (cur_b.low >= 0) check("gap_low_cycles", cyc - fall_cyc, cur_b.low);
        end
      end
      if (!pwm_if.pwm_en && en_prev) begin
        fall_cyc = cyc;
        if (have_b) begin
          if (cur_b.hi >= 0) check("burst_high_cycles", cyc - rise_cyc, cur_b.hi);
          check("pat_held", pwm_if.PAT, cur_b.pat);
          have_b = 1'b0;
        end
      end
      if (seq_done) begin
        done_t d;
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          d = exp_done_q.pop_front();
          check("done_err", err, d.err);
          check("done_en_low", pwm_if.pwm_en, 0);
          if (d.lat >= 0) check("done_latency", cyc - fall_cyc, d.lat);
        end
      end
      en_prev = pwm_if.pwm_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_desc(int a, int duty, int dessert, int pnum, int pat, int dwell);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_duty = 8'(duty);
    cfg_dessert = 16'(dessert);
    cfg_pnum = 8'(pnum);
    cfg_pat = 16'(pat);
    cfg_dwell = 16'(dwell);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_seq(int len, int loops, output int t);
    seq_len = 4'(len);
    loop_cnt = 8'(loops);
    start = 1'b1;
    t = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic push_burst(int idx, int duty, int dessert, int pnum, int pat, int hi, int low);
    burst_t b;
    b = '{idx: idx, duty: duty, dessert: dessert, pnum: pnum, pat: pat, hi: hi, low: low};
    exp_burst_q.push_back(b);
  endtask

  task automatic push_done(int e, int lat);
    done_t d;
    d = '{err: e, lat: lat};
    exp_done_q.push_back(d);
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    @(negedge clk);
    while (!seq_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!seq_done) check("done_timeout", 0, 1);
    tick();
    @(negedge clk);
    check("idle_not_busy", seq_busy, 0);
    tick();
  endtask

  task automatic check_drained();
    check("bursts_outstanding", exp_burst_q.size(), 0);
    check("dones_outstanding", exp_done_q.size(), 0);
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) tick();
    @(negedge clk);
    check("rst_pwm_en", pwm_if.pwm_en, 0);
    check("rst_duty", pwm_if.duty_num, 0);
    check("rst_dessert", pwm_if.pulse_dessert, 0);
    check("rst_pnum", pwm_if.pulse_num, 0);
    check("rst_pat", pwm_if.PAT, 0);
    check("rst_busy", seq_busy, 0);
    check("rst_done", seq_done, 0);
    check("rst_idx", cur_idx, 0);
    check("rst_err", err, 0);
    tick();
    rst = 1'b0;
    tick();

    tag = "T1";
    write_desc(0, 1, 16'h10, 2, 16'hAA, 0);
    push_burst(0, 1, 16'h10, 2, 16'hAA, 6, -1);
    push_done(0, 2);
    start_seq(1, 1, t);
    @(negedge clk);
    check("en_low_in_load", pwm_if.pwm_en, 0);
    check("fields_in_load", pwm_if.duty_num, 1);
    check("busy_after_start", seq_busy, 1);
    @(negedge clk);
    check("en_high_t2", pwm_if.pwm_en, 1);
    wait_done(200);
    check_drained();

    tag = "T2";
    write_desc(0, 2, 16'h20, 1, 16'h1234, 0);
    write_desc(1, 3, 16'h30, 2, 16'h5555, 0);
    write_desc(2, 4, 16'h40, 3, 16'hF0F0, 0);
    for (int p = 0; p < 2; p++) begin
      push_burst(0, 2, 16'h20, 1, 16'h1234, 3, (p == 0) ? -1 : 3);
      push_burst(1, 3, 16'h30, 2, 16'h5555, 6, 3);
      push_burst(2, 4, 16'h40, 3, 16'hF0F0, 9, 3);
    end
    push_done(0, 2);
    start_seq(3, 2, t);
    wait_done(500);
    check_drained();

    tag = "T3";
    write_desc(0, 1, 5, 0, 16'h001F, 200);
    push_burst(0, 1, 5, 0, 16'h001F, 200, -1);
    push_done(0, 5);
    start_seq(1, 1, t);
    wait_done(400);
    check_drained();

    tag = "T4";
    write_desc(0, 5, 16'h50, 10, 16'hAAAA, 0);
    write_desc(1, 6, 16'h60, 20, 16'h5555, 0);
    for (int k = 0; k < 63; k++) begin
      if (k % 2 == 0)
        push_burst(0, 5, 16'h50, 10, 16'hAAAA, (k == 62) ? 23 : 30, (k == 0) ? -1 : 3);
      else
        push_burst(1, 6, 16'h60, 20, 16'h5555, 60, 3);
    end
    push_done(0, 3);
    start_seq(2, 0, t);
    while (cyc < t + 3000) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(200);
    repeat (40) tick();
    check_drained();

    tag = "T5";
    vld_ena = 1'b0;
    write_desc(0, 7, 16'h70, 1, 16'hBEEF, 0);
    push_burst(0, 7, 16'h70, 1, 16'hBEEF, 101, -1);
    push_done(1, 0);
    start_seq(1, 1, t);
    wait_done(300);
    check("err_sticky", err, 1);
    vld_ena = 1'b1;
    repeat (5) tick();
    check_drained();

    tag = "T6";
    push_done(0, -1);
    start_seq(0, 1, t);
    @(negedge clk);
    check("len0_done_t1", seq_done, 1);
    check("len0_busy_t1", seq_busy, 1);
    check("len0_en", pwm_if.pwm_en, 0);
    check("len0_err_cleared", err, 0);
    tick();
    @(negedge clk);
    check("len0_idle", seq_busy, 0);
    tick();
    write_desc(0, 9, 16'h90, 1, 16'h0909, 0);
    push_burst(0, 9, 16'h90, 1, 16'h0909, 3, -1);
    push_done(0, 2);
    push_burst(0, 9, 16'h90, 1, 16'h0909, 3, -1);
    push_done(0, 2);
    start_seq(1, 1, t);
    write_desc(0, 16'hEE, 16'hEEEE, 4, 16'hEEEE, 0);
    seq_len = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200);
    start_seq(1, 1, t);
    wait_done(200);
    repeat (10) tick();
    check_drained();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
